// File: rtl/bsg_circular_ptr_pair_if.sv
// Request/status bundle for the circular pointer pair: enqueue/dequeue counts in,
// registered pointers, next pointers, occupancy and sticky error flags out.
interface bsg_circular_ptr_pair_if #(
    parameter int slots_p   = 12,
    parameter int max_add_p = 3
);
    localparam int ptr_w = ($clog2(slots_p) > 1) ? $clog2(slots_p) : 1;
    localparam int add_w = $clog2(max_add_p + 1);
    localparam int cnt_w = $clog2(slots_p + 1);

    logic [add_w-1:0] enq_cnt_i;
    logic [add_w-1:0] deq_cnt_i;
    logic [ptr_w-1:0] wptr_o;
    logic [ptr_w-1:0] rptr_o;
    logic [ptr_w-1:0] wptr_n_o;
    logic [ptr_w-1:0] rptr_n_o;
    logic [cnt_w-1:0] count_o;
    logic [cnt_w-1:0] free_o;
    logic             empty_o;
    logic             full_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output enq_cnt_i, deq_cnt_i,
        input  wptr_o, rptr_o, wptr_n_o, rptr_n_o, count_o, free_o,
        input  empty_o, full_o, overflow_o, underflow_o
    );

    modport slave (
        input  enq_cnt_i, deq_cnt_i,
        output wptr_o, rptr_o, wptr_n_o, rptr_n_o, count_o, free_o,
        output empty_o, full_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/bsg_circular_ptr_pair.sv
// Read/write pointer pair over a ring of slots_p entries with occupancy count.
// Each side is accepted independently against the current-cycle count/free.
module bsg_circular_ptr_pair #(
    parameter int slots_p   = 12,
    parameter int max_add_p = 3
) (
    input logic                    clk,
    input logic                    reset_n_i,
    bsg_circular_ptr_pair_if.slave bus
);
    localparam int ptr_w = ($clog2(slots_p) > 1) ? $clog2(slots_p) : 1;
    localparam int cnt_w = $clog2(slots_p + 1);
    localparam logic [ptr_w:0]   slots_sum = (ptr_w + 1)'(slots_p);
    localparam logic [cnt_w-1:0] slots_cnt = cnt_w'(slots_p);

    logic [ptr_w-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic [cnt_w-1:0] free, enq_ext, deq_ext, enq_acc, deq_acc;
    logic             enq_ok, deq_ok;
    logic [ptr_w:0]   wsum, rsum;

    assign free    = slots_cnt - count_q;
    assign enq_ext = cnt_w'(bus.enq_cnt_i);
    assign deq_ext = cnt_w'(bus.deq_cnt_i);
    assign enq_ok  = (enq_ext <= free);
    assign deq_ok  = (deq_ext <= count_q);
    assign enq_acc = enq_ok ? enq_ext : '0;
    assign deq_acc = deq_ok ? deq_ext : '0;

    // Sum is < 2*slots_p, so one conditional subtract completes the modulo.
    assign wsum   = {1'b0, wptr_q} + (ptr_w + 1)'(enq_acc);
    assign rsum   = {1'b0, rptr_q} + (ptr_w + 1)'(deq_acc);
    assign wptr_d = (wsum >= slots_sum) ? ptr_w'(wsum - slots_sum) : wsum[ptr_w-1:0];
    assign rptr_d = (rsum >= slots_sum) ? ptr_w'(rsum - slots_sum) : rsum[ptr_w-1:0];

    assign count_d     = count_q + enq_acc - deq_acc;
    assign overflow_d  = overflow_q | ~enq_ok;
    assign underflow_d = underflow_q | ~deq_ok;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.wptr_o      = wptr_q;
    assign bus.rptr_o      = rptr_q;
    assign bus.wptr_n_o    = wptr_d;
    assign bus.rptr_n_o    = rptr_d;
    assign bus.count_o     = count_q;
    assign bus.free_o      = free;
    assign bus.empty_o     = (count_q == '0);
    assign bus.full_o      = (count_q == slots_cnt);
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;
endmodule
